// File: rtl/mapper_mmc1_if.sv
// ---------------------------------------------------------------------------
// mapper_mmc1_if
//   Cart-side bus bundle for the MMC1 (SxROM) mapper.
//   master : the console/cart bus (drives CPU/PPU bus and cart config,
//            receives memory addresses and selects)
//   slave  : the mapper itself
//   Signals:
//     cpu_addr, cpu_data_i, cpu_rw, romsel  CPU bus
//     ppu_addr                              PPU bus
//     chr_ram, prg_ram                      cart configuration
//     prg_mask, chr_mask, prgram_mask       address AND-masks
//     prg_addr, chr_addr, prgram_addr       memory addresses
//     prg_cs, chr_cs, prgram_cs             chip selects
//     mapper_reg_o                          {3'b000, control}
//     ciram_ce, ciram_a10                   nametable RAM control
//     irq                                   unused interrupt (always 0)
// ---------------------------------------------------------------------------
interface mapper_mmc1_if #(
  parameter int PRG_ROM_DEPTH = 18,
  parameter int CHR_ROM_DEPTH = 17,
  parameter int PRG_RAM_DEPTH = 13
);
  logic [14:0]              cpu_addr;
  logic [7:0]               cpu_data_i;
  logic                     cpu_rw;
  logic                     romsel;
  logic [13:0]              ppu_addr;
  logic                     chr_ram;
  logic                     prg_ram;
  logic [PRG_ROM_DEPTH-1:0] prg_mask;
  logic [CHR_ROM_DEPTH-1:0] chr_mask;
  logic [PRG_RAM_DEPTH-1:0] prgram_mask;
  logic [PRG_ROM_DEPTH-1:0] prg_addr;
  logic [CHR_ROM_DEPTH-1:0] chr_addr;
  logic [PRG_RAM_DEPTH-1:0] prgram_addr;
  logic                     prg_cs;
  logic                     chr_cs;
  logic                     prgram_cs;
  logic [7:0]               mapper_reg_o;
  logic                     ciram_ce;
  logic                     ciram_a10;
  logic                     irq;

  modport master (
    output cpu_addr, cpu_data_i, cpu_rw, romsel, ppu_addr, chr_ram, prg_ram,
           prg_mask, chr_mask, prgram_mask,
    input  prg_addr, chr_addr, prgram_addr, prg_cs, chr_cs, prgram_cs,
           mapper_reg_o, ciram_ce, ciram_a10, irq
  );

  modport slave (
    input  cpu_addr, cpu_data_i, cpu_rw, romsel, ppu_addr, chr_ram, prg_ram,
           prg_mask, chr_mask, prgram_mask,
    output prg_addr, chr_addr, prgram_addr, prg_cs, chr_cs, prgram_cs,
           mapper_reg_o, ciram_ce, ciram_a10, irq
  );
endinterface

// File: rtl/mapper_mmc1.sv
// ---------------------------------------------------------------------------
// mapper_mmc1
//   MMC1 (iNES mapper 1, SxROM). CPU writes to $8000-$FFFF are shifted in
//   one bit at a time; the fifth write loads control, chr0, chr1 or prg,
//   selected by A14..A13 of that fifth write. The registers drive PRG/CHR
//   banking and nametable mirroring; all outputs are combinational.
//   Ports:
//     clk_cpu  CPU clock, one bus cycle per rising edge
//     rst      synchronous, active-high reset
//     bus      mapper_mmc1_if.slave (CPU/PPU bus, masks, addresses, selects)
//   Optional feature:
//     MAPPER_MMC1_WRAM_DISABLE_EN  when defined, prg[4]=1 disables PRG RAM
// ---------------------------------------------------------------------------
module mapper_mmc1 #(
  parameter int PRG_ROM_DEPTH = 18,
  parameter int CHR_ROM_DEPTH = 17,
  parameter int PRG_RAM_DEPTH = 13
) (
  input logic          clk_cpu,
  input logic          rst,
  mapper_mmc1_if.slave bus
);

  logic [4:0]  control_q, control_d;
  logic [4:0]  chr0_q, chr0_d;
  logic [4:0]  chr1_q, chr1_d;
  logic [4:0]  prg_q, prg_d;
  logic [4:0]  shift_q, shift_d;
  logic [2:0]  count_q, count_d;
  logic        wrPrev_q, wrPrev_d;
  logic        wr;
  logic        accepted;
  logic [4:0]  value;
  logic [17:0] prgFull;
  logic [16:0] chrFull;
  logic [31:0] ramFull;
  logic        unusedBits;

  assign wr       = bus.romsel & ~bus.cpu_rw;
  // A write directly following another ROM write is the dummy write of a
  // read-modify-write instruction and must not clock the shifter.
  assign accepted = wr & ~wrPrev_q;
  assign value    = {bus.cpu_data_i[0], shift_q[4:1]};

  // Serial loader: bit 7 resets the shifter, otherwise collect LSB-first and
  // commit on the fifth accepted write to the register picked by A14..A13.
  always_comb begin
    control_d = control_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    shift_d   = shift_q;
    count_d   = count_q;
    wrPrev_d  = wr;
    if (accepted) begin
      if (bus.cpu_data_i[7]) begin
        shift_d   = 5'h00;
        count_d   = 3'd0;
        control_d = control_q | 5'h0C;
      end else if (count_q < 3'd4) begin
        shift_d = value;
        count_d = count_q + 3'd1;
      end else begin
        case (bus.cpu_addr[14:13])
          2'b00:   control_d = value;
          2'b01:   chr0_d    = value;
          2'b10:   chr1_d    = value;
          default: prg_d     = value;
        endcase
        shift_d = 5'h00;
        count_d = 3'd0;
      end
    end
  end

  // Register bank with synchronous reset to power-on values.
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      control_q <= 5'h0C;
      chr0_q    <= 5'h00;
      chr1_q    <= 5'h00;
      prg_q     <= 5'h00;
      shift_q   <= 5'h00;
      count_q   <= 3'd0;
      wrPrev_q  <= 1'b0;
    end else begin
      control_q <= control_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      wrPrev_q  <= wrPrev_d;
    end
  end

  // PRG banking: 32KB mode ignores prg[0]; 16KB modes fix one half either
  // to bank 0 or to the all-ones bank (prg_mask trims it to the last bank).
  always_comb begin
    prgFull = {prg_q[3:1], bus.cpu_addr};
    case (control_q[3:2])
      2'b10:   prgFull = {(bus.cpu_addr[14] ? prg_q[3:0] : 4'h0), bus.cpu_addr[13:0]};
      2'b11:   prgFull = {(bus.cpu_addr[14] ? 4'hF : prg_q[3:0]), bus.cpu_addr[13:0]};
      default: prgFull = {prg_q[3:1], bus.cpu_addr};
    endcase
  end

  // CHR banking: one 8KB bank (chr0 without its LSB) or two 4KB banks.
  always_comb begin
    if (control_q[4]) begin
      chrFull = {(bus.ppu_addr[12] ? chr1_q : chr0_q), bus.ppu_addr[11:0]};
    end else begin
      chrFull = {chr0_q[4:1], bus.ppu_addr[12:0]};
    end
  end

  // Nametable mirroring: one-screen low/high, vertical, horizontal.
  always_comb begin
    case (control_q[1:0])
      2'b00:   bus.ciram_a10 = 1'b0;
      2'b01:   bus.ciram_a10 = 1'b1;
      2'b10:   bus.ciram_a10 = bus.ppu_addr[10];
      default: bus.ciram_a10 = bus.ppu_addr[11];
    endcase
  end

  assign ramFull          = {17'd0, bus.cpu_addr};
  assign bus.prg_addr     = prgFull[PRG_ROM_DEPTH-1:0] & bus.prg_mask;
  assign bus.chr_addr     = chrFull[CHR_ROM_DEPTH-1:0] & bus.chr_mask;
  assign bus.prgram_addr  = ramFull[PRG_RAM_DEPTH-1:0] & bus.prgram_mask;
  assign bus.prg_cs       = bus.romsel;
  assign bus.ciram_ce     = bus.ppu_addr[13];
  assign bus.chr_cs       = ~bus.ppu_addr[13];
  assign bus.mapper_reg_o = {3'b000, control_q};
  assign bus.irq          = 1'b0;

`ifdef MAPPER_MMC1_WRAM_DISABLE_EN
  assign bus.prgram_cs = bus.prg_ram & ~bus.romsel & (bus.cpu_addr[14:13] == 2'b11) & ~prg_q[4];
`else
  assign bus.prgram_cs = bus.prg_ram & ~bus.romsel & (bus.cpu_addr[14:13] == 2'b11);
`endif

  // Data bits 6..1 carry nothing for MMC1; CHR RAM banks exactly like ROM.
  assign unusedBits = ^{bus.cpu_data_i[6:1], bus.chr_ram, prg_q[4], ramFull[31:PRG_RAM_DEPTH]};

endmodule
